// File: rtl/uart_imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package uart_imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;

  // Byte receiver states
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Image loader states
  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    HOLD,
    DONE
  } ld_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling, LSB-first
// deserialisation.
//   clock, reset   : system clock, synchronous active-high reset
//   rx_i           : asynchronous serial input, idle high
//   byte_valid_o   : one-cycle pulse, byte_o holds a good byte
//   byte_o         : last received byte
//   stop_err_o     : one-cycle pulse, stop bit sampled low (byte discarded)
module uart_rx_byte
  import uart_imem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_i,
  output logic              byte_valid_o,
  output logic [BYTE_W-1:0] byte_o,
  output logic              stop_err_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic              sync1_q, sync2_q, prev_q;
  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              valid_q, valid_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              err_q, err_d;

  // Synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Receiver state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      byte_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      byte_q  <= byte_d;
      err_q   <= err_d;
    end
  end

  // Bit timing and deserialisation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    byte_d  = byte_q;
    err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        // Mid start bit: a high line here means the edge was a glitch
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[BYTE_W-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sync2_q) begin
            valid_d = 1'b1;
            byte_d  = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid_o = valid_q;
  assign byte_o       = byte_q;
  assign stop_err_o   = err_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: receives a length-prefixed little-endian word image over UART
// and writes it through the processor's instruction-memory load port, holding
// the processor in reset until the image is complete.
//   clock, reset : system clock, synchronous active-high reset
//   rx           : UART serial input, idle high
//   insMemEn     : load-port enable (high for the whole load)
//   insMemData   : assembled word, insMemAddr : word index
//   cpuReset     : processor reset, released after the last word is written
//   loadDone     : sticky, image written; frameErr : sticky, bad stop bit seen
module uart_imem_loader
  import uart_imem_loader_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned IMEM_DEPTH   = 512,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx,
  output logic             insMemEn,
  output logic [WIDTH-1:0] insMemData,
  output logic [WIDTH-1:0] insMemAddr,
  output logic             cpuReset,
  output logic             loadDone,
  output logic             frameErr
);

  localparam int unsigned WIDX_W = 16;
  localparam int unsigned BUF_W  = (BYTES_PER_WORD - 1) * BYTE_W;

  logic              rx_valid;
  logic [BYTE_W-1:0] rx_byte;
  logic              rx_err;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock       (clock),
    .reset       (reset),
    .rx_i        (rx),
    .byte_valid_o(rx_valid),
    .byte_o      (rx_byte),
    .stop_err_o  (rx_err)
  );

  ld_state_t         state_q, state_d;
  logic [WIDX_W-1:0] n_q, n_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic              en_q, en_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [WIDTH-1:0]  addr_q, addr_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;

  // Loader state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= LEN0;
      n_q       <= '0;
      bidx_q    <= '0;
      widx_q    <= '0;
      buf_q     <= '0;
      en_q      <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      bidx_q    <= bidx_d;
      widx_q    <= widx_d;
      buf_q     <= buf_d;
      en_q      <= en_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
    end
  end

  // Image parsing and load-port sequencing
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    bidx_d    = bidx_q;
    widx_d    = widx_q;
    buf_d     = buf_q;
    en_d      = en_q;
    data_d    = data_q;
    addr_d    = addr_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    ferr_d    = ferr_q;

    if (rx_err && (state_q != DONE)) ferr_d = 1'b1;

    case (state_q)
      LEN0: begin
        if (rx_valid) begin
          n_d[7:0] = rx_byte;
          en_d     = 1'b1;
          state_d  = LEN1;
        end
      end
      LEN1: begin
        if (rx_valid) begin
          n_d[15:8] = rx_byte;
          if ({rx_byte, n_q[7:0]} == 16'd0) begin
            state_d = HOLD;
          end else begin
            bidx_d  = '0;
            widx_d  = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
          bidx_d = bidx_q + 2'd1;
          case (bidx_q)
            2'd0: buf_d[7:0]   = rx_byte;
            2'd1: buf_d[15:8]  = rx_byte;
            2'd2: buf_d[23:16] = rx_byte;
            default: begin
              // Whole word commits at once; out-of-range words are dropped
              if ({16'd0, widx_q} < IMEM_DEPTH) begin
                data_d = WIDTH'({rx_byte, buf_q});
                addr_d = WIDTH'(widx_q);
              end
              widx_d = widx_q + 16'd1;
              if (widx_q + 16'd1 == n_q) state_d = HOLD;
            end
          endcase
        end
      end
      HOLD: begin
        // Enable stays high this cycle so the final word is written
        en_d    = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        cpu_rst_d = 1'b0;
        done_d    = 1'b1;
      end
      default: state_d = LEN0;
    endcase
  end

  assign insMemEn   = en_q;
  assign insMemData = data_q;
  assign insMemAddr = addr_q;
  assign cpuReset   = cpu_rst_q;
  assign loadDone   = done_q;
  assign frameErr   = ferr_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Scoreboard bench for uart_imem_loader (CLKS_PER_BIT=4, IMEM_DEPTH=2).
module tb_uart_imem_loader;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 2;

  logic        clock;
  logic        reset;
  logic        rx;
  logic        insMemEn;
  logic [31:0] insMemData;
  logic [31:0] insMemAddr;
  logic        cpuReset;
  logic        loadDone;
  logic        frameErr;

  uart_imem_loader #(
    .WIDTH       (32),
    .IMEM_DEPTH  (DEPTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .insMemEn  (insMemEn),
    .insMemData(insMemData),
    .insMemAddr(insMemAddr),
    .cpuReset  (cpuReset),
    .loadDone  (loadDone),
    .frameErr  (frameErr)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] tx_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         last_upd_cyc = 0;
  int         en_fall_cyc = 0;
  int         cr_fall_cyc = 0;
  bit         en_rise_seen = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every change of addr/data outside reset is a write event
  initial begin : monitor
    logic [31:0] p_addr, p_data;
    logic        p_en, p_cr;
    wr_t         e;
    p_addr = '0; p_data = '0; p_en = 1'b0; p_cr = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (!reset) begin
        if (insMemAddr !== p_addr || insMemData !== p_data) begin
          last_upd_cyc = cyc;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: addr=%h data=%h want none", insMemAddr, insMemData);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", insMemAddr, e.addr);
            check("wr_data", insMemData, e.data);
            check("wr_en", {31'd0, insMemEn}, 32'd1);
          end
        end
        if (p_en && !insMemEn) en_fall_cyc = cyc;
        if (!p_en && insMemEn) en_rise_seen = 1;
        if (p_cr && !cpuReset) cr_fall_cyc = cyc;
      end
      p_addr = insMemAddr; p_data = insMemData; p_en = insMemEn; p_cr = cpuReset;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_all();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
  endtask

  task automatic push_len(input logic [15:0] n);
    tx_q.push_back(n[7:0]);
    tx_q.push_back(n[15:8]);
  endtask

  task automatic push_word(input logic [31:0] w, input logic [31:0] a, input bit expect_wr);
    wr_t e;
    for (int i = 0; i < 4; i++) tx_q.push_back(w[8*i +: 8]);
    if (expect_wr) begin
      e.addr = a;
      e.data = w;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    en_rise_seen = 0;
    @(negedge clock);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_en"},   {31'd0, insMemEn}, 32'd0);
    check({tag, "_data"}, insMemData, 32'd0);
    check({tag, "_addr"}, insMemAddr, 32'd0);
    check({tag, "_cpurst"}, {31'd0, cpuReset}, 32'd1);
    check({tag, "_done"}, {31'd0, loadDone}, 32'd0);
    check({tag, "_ferr"}, {31'd0, frameErr}, 32'd0);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000 && !loadDone; i++) @(negedge clock);
    check({tag, "_loaddone"}, {31'd0, loadDone}, 32'd1);
    repeat (4) @(negedge clock);
    check({tag, "_cpurst_low"}, {31'd0, cpuReset}, 32'd0);
    check({tag, "_en_low"}, {31'd0, insMemEn}, 32'd0);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : stimulus
    reset = 1'b1;
    rx    = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;

    // Reset state after idle line
    repeat (100) @(negedge clock);
    check_reset_vals("rst");

    // Two-word image
    push_len(16'd2);
    push_word(32'h0000_0013, 32'd0, 1);
    push_word(32'h0000_10B7, 32'd1, 1);
    send_all();
    wait_done("img2");
    check("img2_en_fall_lat", 32'(en_fall_cyc - last_upd_cyc), 32'd1);
    check("img2_rst_fall_lat", 32'(cr_fall_cyc - en_fall_cyc), 32'd1);
    check("img2_keep_data", insMemData, 32'h0000_10B7);
    check("img2_keep_addr", insMemAddr, 32'd1);
    // Bytes after DONE are ignored
    send_byte(8'hFF, 1'b1);
    repeat (10) @(negedge clock);
    check("after_done_data", insMemData, 32'h0000_10B7);
    check("after_done_en", {31'd0, insMemEn}, 32'd0);

    // Empty image
    do_reset();
    push_len(16'd0);
    send_all();
    wait_done("empty");
    check("empty_en_pulsed", {31'd0, en_rise_seen}, 32'd1);
    check("empty_rst_fall_lat", 32'(cr_fall_cyc - en_fall_cyc), 32'd1);
    check("empty_data", insMemData, 32'd0);
    check("empty_addr", insMemAddr, 32'd0);

    // Word beyond memory depth is dropped
    do_reset();
    push_len(16'd3);
    push_word(32'h1111_1111, 32'd0, 1);
    push_word(32'h2222_2222, 32'd1, 1);
    push_word(32'h3333_3333, 32'd2, 0);
    send_all();
    wait_done("depth");
    check("depth_data", insMemData, 32'h2222_2222);
    check("depth_addr", insMemAddr, 32'd1);

    // One-cycle low glitch while idle
    do_reset();
    rx = 1'b0;
    @(negedge clock);
    rx = 1'b1;
    repeat (50) @(negedge clock);
    check("glitch_en", {31'd0, insMemEn}, 32'd0);
    check("glitch_ferr", {31'd0, frameErr}, 32'd0);
    push_len(16'd1);
    push_word(32'hAABB_CCDD, 32'd0, 1);
    send_all();
    wait_done("glitch");
    check("glitch_data", insMemData, 32'hAABB_CCDD);

    // Bad stop bit mid-word: byte lost, loader keeps counting
    do_reset();
    push_len(16'd2);
    send_all();
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'hEE, 1'b0);
    repeat (CPB) @(negedge clock);
    check("ferr_set", {31'd0, frameErr}, 32'd1);
    push_word(32'h0000_0000, 32'd0, 0);
    tx_q.delete();
    tx_q.push_back(8'h03);
    tx_q.push_back(8'h04);
    begin
      wr_t e;
      e.addr = 32'd0; e.data = 32'h0403_0201; exp_q.push_back(e);
    end
    push_word(32'h8877_6655, 32'd1, 1);
    send_all();
    wait_done("ferr");
    check("ferr_sticky", {31'd0, frameErr}, 32'd1);
    check("ferr_data", insMemData, 32'h8877_6655);

    // Reset in the middle of a word, then a clean reload
    do_reset();
    push_len(16'd2);
    tx_q.push_back(8'hAA);
    tx_q.push_back(8'hBB);
    send_all();
    check("midword_en_high", {31'd0, insMemEn}, 32'd1);
    do_reset();
    check_reset_vals("midrst");
    push_len(16'd2);
    push_word(32'h0000_0013, 32'd0, 1);
    push_word(32'h0000_10B7, 32'd1, 1);
    send_all();
    wait_done("reload");
    check("reload_data", insMemData, 32'h0000_10B7);
    check("reload_addr", insMemAddr, 32'd1);

    repeat (5) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
